// File: rtl/morse_pkg.sv
// Shared types, default timing and the digit-to-Morse code table for the keyer.
package morse_pkg;

    typedef enum logic [2:0] {StIdle, StLoad, StMark, StSpace, StCgap} state_e;

    localparam int unsigned DefUnitCycles   = 4;
    localparam int unsigned DefFifoDepth    = 4;
    localparam int unsigned DefDashUnits    = 3;
    localparam int unsigned DefCharGapUnits = 3;
    localparam int unsigned NumSymbols      = 5;

    // bit0 is sent first; 1 = dot, 0 = dash
    function automatic logic [4:0] digit_code(input logic [3:0] d);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NumSymbols; i++) begin
            if (d <= 4'd5) c[i] = (i < int'(d));
            else           c[i] = (i >= int'(d) - 5);
        end
        return c;
    endfunction

endpackage

// File: rtl/morse_if.sv
// Digit push handshake plus keying outputs of the Morse keyer.
interface morse_if;
    import morse_pkg::*;

    logic [3:0] num;
    logic       ready;
    logic       in_ready;
    logic       err;
    logic       abort;
    logic       key;
    logic [4:0] morse;
    logic       busy;

    modport master (output num, ready, abort, input in_ready, err, key, morse, busy);
    modport slave  (input num, ready, abort, output in_ready, err, key, morse, busy);

endinterface

// File: rtl/morse_fifo.sv
// Power-of-two circular queue with synchronous flush and full/empty flags.
module morse_fifo
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH = DefFifoDepth,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/morse_keyer.sv
// Queues decimal digits and keys them out as 5-symbol Morse characters.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES    = DefUnitCycles,
    parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
    parameter int unsigned DASH_UNITS     = DefDashUnits,
    parameter int unsigned CHAR_GAP_UNITS = DefCharGapUnits
) (
    input logic    clk,
    input logic    reset,
    morse_if.slave bus
);
    localparam int unsigned DotLen  = UNIT_CYCLES;
    localparam int unsigned DashLen = DASH_UNITS * UNIT_CYCLES;
    localparam int unsigned GapLen  = CHAR_GAP_UNITS * UNIT_CYCLES;
    localparam int unsigned MaxLen  = (DashLen > GapLen) ?
                                      ((DashLen > DotLen) ? DashLen : DotLen) :
                                      ((GapLen > DotLen) ? GapLen : DotLen);
    localparam int unsigned CntW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t DotLast  = cnt_t'(DotLen - 1);
    localparam cnt_t DashLast = cnt_t'(DashLen - 1);
    localparam cnt_t GapLast  = cnt_t'(GapLen - 1);

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d, last_cnt;
    logic [2:0] idx_q, idx_d;
    logic [4:0] morse_q, morse_d;
    logic       err_q, err_d;
    logic       full, empty, push, pop;
    logic [3:0] head;

    // A push coincident with abort is dropped along with the queue contents
    assign push  = bus.ready && !full && !bus.abort && (bus.num <= 4'd9);
    assign err_d = bus.ready && !full && !bus.abort && (bus.num > 4'd9);
    assign pop   = (state_q == StLoad);

    morse_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(4)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(bus.abort),
        .push (push),
        .wdata(bus.num),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            morse_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            morse_q <= morse_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            StMark:  last_cnt = morse_q[idx_q] ? DotLast : DashLast;
            StCgap:  last_cnt = GapLast;
            default: last_cnt = DotLast;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        morse_d = morse_q;
        if (bus.abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: if (!empty) state_d = StLoad;
                StLoad: begin
                    morse_d = digit_code(head);
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StMark;
                end
                StMark: begin
                    if (cnt_q == last_cnt) begin
                        cnt_d   = '0;
                        state_d = (idx_q == 3'(NumSymbols - 1)) ? StCgap : StSpace;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                StSpace: begin
                    if (cnt_q == last_cnt) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        state_d = StMark;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                StCgap: begin
                    if (cnt_q == last_cnt) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.key      = (state_q == StMark);
    assign bus.busy     = !empty || (state_q != StIdle);
    assign bus.in_ready = !full;
    assign bus.err      = err_q;
    assign bus.morse    = morse_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench: per-cycle waveform reference model plus directed digit table.
module tb_morse_keyer;
    import morse_pkg::*;

    localparam int unsigned U     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DASH  = 3;
    localparam int unsigned CG    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    morse_if bus();

    morse_keyer #(
        .UNIT_CYCLES   (U),
        .FIFO_DEPTH    (DEPTH),
        .DASH_UNITS    (DASH),
        .CHAR_GAP_UNITS(CG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digits waiting, and the key level for the current and future cycles
    int         mq[$];
    bit         mw[$];
    bit         pop_pend = 1'b0;
    bit         m_err    = 1'b0;
    logic [4:0] m_morse  = 5'b0;

    function automatic logic [4:0] ref_code(input int d);
        logic [5:0] v;
        if (d == 0) return 5'b00000;
        if (d <= 5) begin
            v = 6'((1 << d) - 1);
            return v[4:0];
        end
        v = 6'(6'b011111 << (d - 5));
        return v[4:0];
    endfunction

    task automatic queue_char(input int d);
        logic [4:0] c;
        c = ref_code(d);
        mw.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            repeat (c[i] ? U : DASH * U) mw.push_back(1'b1);
            repeat ((i < 4) ? U : CG * U) mw.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit idle_before, qne, acc;
        if (!reset) begin
            mq.delete(); mw.delete();
            pop_pend = 1'b0; m_err = 1'b0; m_morse = 5'b0;
            return;
        end
        idle_before = (mw.size() == 0);
        qne         = (mq.size() > 0);
        acc         = bus.ready && (mq.size() < DEPTH);
        if (bus.abort) begin
            mq.delete(); mw.delete();
            pop_pend = 1'b0; m_err = 1'b0;
            return;
        end
        if (!idle_before) void'(mw.pop_front());
        if (pop_pend) begin
            m_morse  = ref_code(mq.pop_front());
            pop_pend = 1'b0;
        end
        if (idle_before && qne) begin
            queue_char(mq[0]);
            pop_pend = 1'b1;
        end
        m_err = acc && (bus.num > 4'd9);
        if (acc && bus.num <= 4'd9) mq.push_back(int'(bus.num));
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("mdl_key", bus.key, (mw.size() > 0) ? mw[0] : 1'b0);
        check("mdl_busy", bus.busy, (mq.size() > 0) || (mw.size() > 0));
        check("mdl_in_ready", bus.in_ready, mq.size() < DEPTH);
        check("mdl_err", bus.err, m_err);
        check("mdl_morse", bus.morse, m_morse);
    end

    // Records each newly loaded code
    logic [4:0] seen[$];
    logic [4:0] prev_morse = 5'b0;
    bit         rec_en     = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rec_en && bus.morse !== prev_morse) seen.push_back(bus.morse);
        prev_morse = bus.morse;
    end

    typedef struct {
        int         digit;
        logic [4:0] code;
    } vec_t;
    vec_t vecs[10];

    task automatic run_digit(input int d, input logic [4:0] code);
        int n;
        bus.num = 4'(d); bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check($sformatf("d%0d_lat0", d), bus.key, 1'b0);
        @(negedge clk);
        check($sformatf("d%0d_lat1", d), bus.key, 1'b0);
        @(negedge clk);
        check($sformatf("d%0d_rise", d), bus.key, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (bus.key === 1'b1 && n < 100) begin n++; @(negedge clk); end
            check($sformatf("d%0d_mark%0d", d, i), n, code[i] ? U : DASH * U);
            n = 0;
            while (bus.key === 1'b0 && bus.busy === 1'b1 && n < 100) begin
                n++; @(negedge clk);
            end
            check($sformatf("d%0d_gap%0d", d, i), n, (i < 4) ? U : CG * U);
        end
        check($sformatf("d%0d_morse", d), bus.morse, code);
    endtask

    initial begin
        int d, first_low, n, highs;
        vecs[0] = '{0, 5'b00000}; vecs[1] = '{1, 5'b00001};
        vecs[2] = '{2, 5'b00011}; vecs[3] = '{3, 5'b00111};
        vecs[4] = '{4, 5'b01111}; vecs[5] = '{5, 5'b11111};
        vecs[6] = '{6, 5'b11110}; vecs[7] = '{7, 5'b11100};
        vecs[8] = '{8, 5'b11000}; vecs[9] = '{9, 5'b10000};

        bus.num = 4'd0; bus.ready = 1'b0; bus.abort = 1'b0;
        #2;
        check("rst_key", bus.key, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_morse", bus.morse, 5'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_digit(vecs[i].digit, vecs[i].code);

        // Invalid digit
        @(negedge clk);
        bus.num = 4'd12; bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check("bad_err", bus.err, 1'b1);
        check("bad_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("bad_err_clear", bus.err, 1'b0);
        check("bad_busy2", bus.busy, 1'b0);
        check("bad_key", bus.key, 1'b0);

        // Back-to-back 0..9 with backpressure
        rec_en = 1'b1; d = 0; first_low = -1; n = 0;
        while (d < 10 && n < 3000) begin
            bus.num = 4'(d);
            bus.ready = bus.in_ready;
            if (!bus.in_ready && first_low < 0) first_low = d;
            if (bus.in_ready) d++;
            @(negedge clk); n++;
        end
        bus.ready = 1'b0;
        check("b2b_pushed", d, 10);
        check("b2b_full_at", first_low, 5);
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        check("b2b_drained", bus.busy, 1'b0);
        rec_en = 1'b0;
        check("b2b_count", seen.size(), 10);
        for (int i = 0; i < 10 && i < seen.size(); i++)
            check($sformatf("b2b_order%0d", i), seen[i], vecs[i].code);

        // Abort mid-dash of 7 with two digits queued
        foreach (vecs[i]) if (i == 7 || i == 1 || i == 2) begin end
        bus.ready = 1'b1; bus.num = 4'd7; @(negedge clk);
        bus.num = 4'd1; @(negedge clk);
        bus.num = 4'd2; @(negedge clk);
        bus.ready = 1'b0;
        n = 0;
        while (bus.key !== 1'b1 && n < 50) begin n++; @(negedge clk); end
        repeat (5) @(negedge clk);
        check("abort_pre_key", bus.key, 1'b1);
        bus.abort = 1'b1; bus.ready = 1'b1; bus.num = 4'd3;
        @(negedge clk);
        bus.abort = 1'b0; bus.ready = 1'b0;
        check("abort_key", bus.key, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        highs = 0;
        repeat (30) begin @(negedge clk); if (bus.key !== 1'b0 || bus.busy !== 1'b0) highs++; end
        check("abort_quiet", highs, 0);

        // Reset mid-mark
        bus.ready = 1'b1; bus.num = 4'd8; @(negedge clk);
        bus.ready = 1'b0;
        n = 0;
        while (bus.key !== 1'b1 && n < 50) begin n++; @(negedge clk); end
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rstmid_key", bus.key, 1'b0);
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_morse", bus.morse, 5'b0);
        @(negedge clk);
        reset = 1'b1;
        run_digit(3, vecs[3].code);

        // Random traffic against the model
        repeat (800) begin
            @(negedge clk);
            bus.ready = ($urandom_range(0, 2) == 0);
            bus.num   = 4'($urandom_range(0, 11));
            bus.abort = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        bus.ready = 1'b0; bus.abort = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        check("rand_drained", bus.busy, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter UNIT_CYCLES, default 4, clock cycles per Morse time unit (>=1).
REQ-002 Parameter FIFO_DEPTH, default 4, digit queue entries (power of two, >=2).
REQ-003 Parameter DASH_UNITS, default 3, dash length in units.
REQ-004 Parameter CHAR_GAP_UNITS, default 3, silence after each character in units.
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 num  input  4  digit to transmit (0-9 valid).
REQ-008 ready  input  1  num valid this cycle (push request).
REQ-009 in_ready  output  1  queue can accept a digit.
REQ-010 err  output  1  one-cycle pulse: accepted push carried num > 9.
REQ-011 abort  input  1  synchronous flush of queue and current character.
REQ-012 key  output  1  keying line, 1 = tone on.
REQ-013 morse  output  5  code of character in transmission; bit0 first symbol; 1 = dot, 0 = dash.
REQ-014 busy  output  1  high while queue non-empty or FSM not IDLE.

Function
REQ-015 Push occurs on edge where ready=1 and in_ready=1; in_ready = queue not full.
REQ-016 Push with num > 9 SHALL NOT be enqueued; err=1 for the following cycle only.
REQ-017 Code table: digits 1-5 = n dots then dashes; 6-9 = (n-5) dashes then dots; 0 = five dashes.
REQ-018 FSM states IDLE, LOAD, MARK, SPACE, CGAP; IDLE->LOAD when queue non-empty.
REQ-019 LOAD lasts one cycle: pops head, latches code into morse, symbol index = 0.
REQ-020 MARK: key=1 for UNIT_CYCLES (dot) or DASH_UNITS*UNIT_CYCLES (dash) cycles.
REQ-021 After MARK of symbols 0-3 -> SPACE (key=0, UNIT_CYCLES cycles) -> MARK of next symbol.
REQ-022 After MARK of symbol 4 -> CGAP (key=0, CHAR_GAP_UNITS*UNIT_CYCLES cycles) -> IDLE.
REQ-023 With queue empty and FSM IDLE, key rises exactly 2 cycles after the accepting edge.
REQ-024 Back-to-back digits: next LOAD immediately follows CGAP via IDLE (one IDLE cycle).
REQ-025 Push while full is ignored; no err, no queue change.
REQ-026 Push and pop in same cycle both take effect; occupancy unchanged.
REQ-027 abort=1: next cycle FSM=IDLE, key=0, queue empty; push coincident with abort is discarded.
REQ-028 morse holds last loaded code through IDLE until next LOAD.
REQ-029 Unit counter wraps per phase; no state lasts a cycle longer than specified.

Reset
REQ-030 reset low: immediately key=0, err=0, morse=0, busy=0, in_ready=1, FSM=IDLE, queue empty.
REQ-031 Reset mid-character abandons it; no residual symbols after release.
REQ-032 First push is accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Package morse_pkg holds FSM state typedef, digit-to-code function and default timing constants.
REQ-034 Queue is sub-module morse_fifo (parametrised depth/width, full/empty flags).
REQ-035 Timing counter and FSM reside in morse_keyer; no other sub-modules.

Verification
REQ-036 UNIT_CYCLES=4: push 5 -> key high 5 pulses of 4 cycles separated by 4-cycle gaps, morse=11111, then 12 cycles low.
REQ-037 Push 1 -> morse=00001... bit0=1, key pulses 4,12,12,12,12 cycles; char length 80 cycles incl. gaps.
REQ-038 Push 0-9 back-to-back, FIFO_DEPTH=4 -> in_ready drops at 4 stored (+1 in flight), all ten transmitted in order, none lost.
REQ-039 Push 12 -> err high one cycle, nothing queued, busy stays 0, key stays 0.
REQ-040 Assert abort mid-dash of digit 7 with 2 queued -> key 0 next cycle, busy 0, queue empty.
REQ-041 Pull reset low mid-mark -> key 0 without clock edge; after release push 3 transmits normally.
